// File: rtl/ppu_pkg.sv
// Shared PPU memory definitions: mode and region encodings, address map
// constants and the address decoder used by every PPU memory block.
package ppu_pkg;

  typedef enum logic [1:0] {
    HBlank  = 2'd0,
    VBlank  = 2'd1,
    OAMScan = 2'd2,
    Draw    = 2'd3
  } PPUState;

  typedef enum logic [1:0] {
    RegVRAM = 2'd0,
    RegOAM  = 2'd1,
    RegNone = 2'd2
  } Region;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFE9F;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

  // $FEA0-$FEFF deliberately falls through to RegNone.
  function automatic Region decode_region(input logic [15:0] a);
    if (a[15:13] == VRAM_BASE[15:13]) return RegVRAM;
    if ((a >= OAM_BASE) && (a <= OAM_END)) return RegOAM;
    return RegNone;
  endfunction

endpackage

// File: rtl/ppu_mem_responder_sync_ram_1r1w.sv
// Simple dual-port RAM: one synchronous read port, one write port,
// write-first when both ports hit the same word on the same edge.
module sync_ram_1r1w #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
    else                              r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ppu_mem_responder.sv
// VRAM/OAM responder: fixed-latency PPU reads, mode-locked CPU access.
// Optional OAM DMA engine enabled with `define PPU_MEM_OAM_DMA_EN.
module ppu_mem_responder
  import ppu_pkg::*;
#(
  parameter int VRAM_BYTES = 8192,
  parameter int OAM_BYTES  = 160,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
`ifdef PPU_MEM_OAM_DMA_EN
  input  logic        dma_start_in,
  input  logic [7:0]  dma_page_in,
  output logic [15:0] dma_addr_out,
  input  logic [7:0]  dma_data_in,
  input  logic        dma_data_valid_in,
  output logic        dma_busy_out,
`endif
  input  logic [1:0]  mode_in,
  input  logic        ppu_req_in,
  input  logic [15:0] ppu_addr_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  input  logic        cpu_req_in,
  input  logic        cpu_we_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic        cpu_ready_out,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_rdata_valid_out
);

  localparam int VAW  = $clog2(VRAM_BYTES);
  localparam int OAW  = $clog2(OAM_BYTES);
  localparam int PIPE = RD_LATENCY;

  Region          w_ppu_reg, w_cpu_reg;
  PPUState        w_mode;
  logic           w_dma_busy, w_oam_lock, w_vram_lock, w_cpu_locked;
  logic           w_conflict, w_cpu_acc, w_cpu_hit;
  logic [VAW-1:0] w_cpu_idx;

  assign w_ppu_reg    = decode_region(ppu_addr_in);
  assign w_cpu_reg    = decode_region(cpu_addr_in);
  assign w_mode       = PPUState'(mode_in);
  assign w_cpu_idx    = cpu_addr_in[VAW-1:0];
  assign w_oam_lock   = (w_mode == OAMScan) || (w_mode == Draw) || w_dma_busy;
  assign w_vram_lock  = (w_mode == Draw);
  assign w_cpu_locked = ((w_cpu_reg == RegVRAM) && w_vram_lock) ||
                        ((w_cpu_reg == RegOAM)  && w_oam_lock);
  // Both pipelines share each RAM's read port one cycle later, so a
  // same-RAM collision is resolved here, at acceptance.
  assign w_conflict   = ppu_req_in && cpu_req_in && (w_cpu_reg == w_ppu_reg) &&
                        (w_cpu_reg != RegNone);
  assign w_cpu_acc    = cpu_req_in && !rst_in && !w_conflict;
  assign w_cpu_hit    = w_cpu_acc && !w_cpu_locked && (w_cpu_reg != RegNone);
  assign cpu_ready_out = w_cpu_acc;

  // Pipeline occupancy per port: v = 00 IDLE, x1 entry in S1, 1x entry in S2.
  logic [PIPE-1:0] r_ppu_v, r_cpu_v;
  Region           r_ppu_reg1, r_ppu_reg2, r_cpu_reg1, r_cpu_reg2;
  logic [VAW-1:0]  r_ppu_idx1, r_cpu_idx1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ppu_v <= '0;
      r_cpu_v <= '0;
    end else begin
      r_ppu_v <= {r_ppu_v[PIPE-2:0], ppu_req_in};
      r_cpu_v <= {r_cpu_v[PIPE-2:0], w_cpu_acc && !cpu_we_in};
    end
    r_ppu_reg1 <= w_ppu_reg;
    r_ppu_idx1 <= ppu_addr_in[VAW-1:0];
    r_ppu_reg2 <= r_ppu_reg1;
    r_cpu_reg1 <= w_cpu_hit ? w_cpu_reg : RegNone;
    r_cpu_idx1 <= w_cpu_idx;
    r_cpu_reg2 <= r_cpu_reg1;
  end

  logic           w_cpu_rd_vram, w_cpu_rd_oam;
  logic [VAW-1:0] w_vram_raddr;
  logic [OAW-1:0] w_oam_raddr;
  logic [7:0]     w_vram_q, w_oam_q;
  logic           w_oam_we;
  logic [OAW-1:0] w_oam_waddr;
  logic [7:0]     w_oam_wdata;

  assign w_cpu_rd_vram = r_cpu_v[0] && (r_cpu_reg1 == RegVRAM);
  assign w_cpu_rd_oam  = r_cpu_v[0] && (r_cpu_reg1 == RegOAM);
  assign w_vram_raddr  = w_cpu_rd_vram ? r_cpu_idx1 : r_ppu_idx1;
  assign w_oam_raddr   = w_cpu_rd_oam ? r_cpu_idx1[OAW-1:0] :
                         (r_ppu_reg1 == RegOAM) ? r_ppu_idx1[OAW-1:0] : '0;

`ifdef PPU_MEM_OAM_DMA_EN
  // state     | meaning
  // DMA_IDLE  | no transfer
  // DMA_REQ   | source address presented for byte i
  // DMA_WAIT  | waiting for source data
  // DMA_WRITE | writing OAM[i]; stalls while the PPU requests OAM
  localparam logic [1:0] DMA_IDLE = 2'd0, DMA_REQ = 2'd1, DMA_WAIT = 2'd2, DMA_WRITE = 2'd3;

  logic [1:0] r_dma_st;
  logic [7:0] r_dma_page, r_dma_idx, r_dma_data;
  logic       w_dma_wr;

  assign w_dma_wr = (r_dma_st == DMA_WRITE) && !dma_start_in &&
                    !(ppu_req_in && (w_ppu_reg == RegOAM));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_dma_st   <= DMA_IDLE;
      r_dma_page <= '0;
      r_dma_idx  <= '0;
      r_dma_data <= '0;
    end else if (dma_start_in) begin
      r_dma_st   <= DMA_REQ;
      r_dma_page <= dma_page_in;
      r_dma_idx  <= '0;
    end else begin
      case (r_dma_st)
        DMA_REQ:  r_dma_st <= DMA_WAIT;
        DMA_WAIT: if (dma_data_valid_in) begin
          r_dma_data <= dma_data_in;
          r_dma_st   <= DMA_WRITE;
        end
        DMA_WRITE: if (w_dma_wr) begin
          if (r_dma_idx == 8'(OAM_BYTES - 1)) r_dma_st <= DMA_IDLE;
          else begin
            r_dma_idx <= r_dma_idx + 8'd1;
            r_dma_st  <= DMA_REQ;
          end
        end
        default: r_dma_st <= DMA_IDLE;
      endcase
    end
  end

  assign w_dma_busy   = (r_dma_st != DMA_IDLE);
  assign dma_busy_out = w_dma_busy;
  assign dma_addr_out = w_dma_busy ? ({r_dma_page, 8'h00} + {8'h00, r_dma_idx}) : 16'h0000;
`else
  assign w_dma_busy = 1'b0;
`endif

  always_comb begin
    w_oam_we    = w_cpu_hit && cpu_we_in && (w_cpu_reg == RegOAM);
    w_oam_waddr = w_cpu_idx[OAW-1:0];
    w_oam_wdata = cpu_wdata_in;
`ifdef PPU_MEM_OAM_DMA_EN
    if (w_dma_wr) begin
      w_oam_we    = 1'b1;
      w_oam_waddr = OAW'(r_dma_idx);
      w_oam_wdata = r_dma_data;
    end
`endif
  end

  sync_ram_1r1w #(.DEPTH(VRAM_BYTES), .WIDTH(8)) u_vram (
    .i_clk   (clk_in),
    .i_we    (w_cpu_hit && cpu_we_in && (w_cpu_reg == RegVRAM)),
    .i_waddr (w_cpu_idx),
    .i_wdata (cpu_wdata_in),
    .i_raddr (w_vram_raddr),
    .o_rdata (w_vram_q)
  );

  sync_ram_1r1w #(.DEPTH(OAM_BYTES), .WIDTH(8)) u_oam (
    .i_clk   (clk_in),
    .i_we    (w_oam_we),
    .i_waddr (w_oam_waddr),
    .i_wdata (w_oam_wdata),
    .i_raddr (w_oam_raddr),
    .o_rdata (w_oam_q)
  );

  always_comb begin
    ppu_data_out = 8'h00;
    if (r_ppu_v[PIPE-1]) begin
      case (r_ppu_reg2)
        RegVRAM: ppu_data_out = w_vram_q;
        RegOAM:  ppu_data_out = w_oam_q;
        default: ppu_data_out = OPEN_BUS;
      endcase
    end
    cpu_rdata_out = 8'h00;
    if (r_cpu_v[PIPE-1]) begin
      case (r_cpu_reg2)
        RegVRAM: cpu_rdata_out = w_vram_q;
        RegOAM:  cpu_rdata_out = w_oam_q;
        default: cpu_rdata_out = OPEN_BUS;
      endcase
    end
  end

  assign ppu_data_valid_out  = r_ppu_v[PIPE-1];
  assign cpu_rdata_valid_out = r_cpu_v[PIPE-1];

endmodule

// File: tb/tb_ppu_mem_responder.sv
// Directed bench for ppu_mem_responder: latency, locking, arbitration, reset.
module tb_ppu_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  mode_in;
  logic        ppu_req_in;
  logic [15:0] ppu_addr_in;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_valid_out;
  logic        cpu_req_in, cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic        cpu_ready_out;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_rdata_valid_out;
`ifdef PPU_MEM_OAM_DMA_EN
  logic        dma_start_in;
  logic [7:0]  dma_page_in;
  logic [15:0] dma_addr_out;
  logic [7:0]  dma_data_in;
  logic        dma_data_valid_in;
  logic        dma_busy_out;
  assign dma_data_in       = dma_addr_out[7:0] ^ 8'hFF;
  assign dma_data_valid_in = 1'b1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  ppu_mem_responder dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
`ifdef PPU_MEM_OAM_DMA_EN
    .dma_start_in        (dma_start_in),
    .dma_page_in         (dma_page_in),
    .dma_addr_out        (dma_addr_out),
    .dma_data_in         (dma_data_in),
    .dma_data_valid_in   (dma_data_valid_in),
    .dma_busy_out        (dma_busy_out),
`endif
    .mode_in             (mode_in),
    .ppu_req_in          (ppu_req_in),
    .ppu_addr_in         (ppu_addr_in),
    .ppu_data_out        (ppu_data_out),
    .ppu_data_valid_out  (ppu_data_valid_out),
    .cpu_req_in          (cpu_req_in),
    .cpu_we_in           (cpu_we_in),
    .cpu_addr_in         (cpu_addr_in),
    .cpu_wdata_in        (cpu_wdata_in),
    .cpu_ready_out       (cpu_ready_out),
    .cpu_rdata_out       (cpu_rdata_out),
    .cpu_rdata_valid_out (cpu_rdata_valid_out)
  );

  task automatic next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input string nm);
    cpu_req_in = 1'b1; cpu_we_in = 1'b1; cpu_addr_in = a; cpu_wdata_in = d;
    #1;
    n_vec++;
    if (cpu_ready_out !== 1'b1) begin
      n_err++; $display("FAIL %s ready: got %b want 1", nm, cpu_ready_out);
    end
    next();
    cpu_req_in = 1'b0; cpu_we_in = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string nm);
    cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = a;
    #1;
    n_vec++;
    if (cpu_ready_out !== 1'b1) begin
      n_err++; $display("FAIL %s ready: got %b want 1", nm, cpu_ready_out);
    end
    next();
    cpu_req_in = 1'b0;
    #1;
    n_vec++;
    if (cpu_rdata_valid_out !== 1'b0) begin
      n_err++; $display("FAIL %s early valid: got %b want 0", nm, cpu_rdata_valid_out);
    end
    next();
    n_vec++;
    if (cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== exp) begin
      n_err++; $display("FAIL %s data: got v=%b d=%h want v=1 d=%h", nm, cpu_rdata_valid_out, cpu_rdata_out, exp);
    end
  endtask

  task automatic ppu_read(input logic [15:0] a, input logic [7:0] exp, input string nm);
    ppu_req_in = 1'b1; ppu_addr_in = a;
    next();
    ppu_req_in = 1'b0;
    #1;
    n_vec++;
    if (ppu_data_valid_out !== 1'b0) begin
      n_err++; $display("FAIL %s early valid: got %b want 0", nm, ppu_data_valid_out);
    end
    next();
    n_vec++;
    if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== exp) begin
      n_err++; $display("FAIL %s data: got v=%b d=%h want v=1 d=%h", nm, ppu_data_valid_out, ppu_data_out, exp);
    end
    next();
    n_vec++;
    if (ppu_data_valid_out !== 1'b0) begin
      n_err++; $display("FAIL %s pulse width: got valid=%b want 0", nm, ppu_data_valid_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; mode_in = 2'd0;
    ppu_req_in = 1'b1; ppu_addr_in = 16'hFE00;
    cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h8000; cpu_wdata_in = 8'h00;
    next();
    next();
    n_vec++;
    if ({ppu_data_out, ppu_data_valid_out, cpu_ready_out, cpu_rdata_out, cpu_rdata_valid_out} !== 19'd0) begin
      n_err++;
      $display("FAIL reset outputs: got pd=%h pv=%b rdy=%b cd=%h cv=%b want all 0",
               ppu_data_out, ppu_data_valid_out, cpu_ready_out, cpu_rdata_out, cpu_rdata_valid_out);
    end
    rst_in = 1'b0; ppu_req_in = 1'b0; cpu_req_in = 1'b0;
    next();
  endtask

  task automatic test_ppu_burst();
    logic [15:0] addrs [3] = '{16'hFE00, 16'hFE01, 16'h8010};
    logic        exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  exp_d [6] = '{8'h00, 8'h00, 8'h20, 8'h08, 8'h3C, 8'h00};
    mode_in = 2'd0;
    cpu_write(16'hFE00, 8'h20, "setup oam0");
    cpu_write(16'hFE01, 8'h08, "setup oam1");
    cpu_write(16'h8010, 8'h3C, "setup vram10");
    cpu_write(16'hFE04, 8'h77, "setup oam4");
    for (int c = 0; c < 6; c++) begin
      ppu_req_in = (c < 3);
      if (c < 3) ppu_addr_in = addrs[c];
      #1;
      n_vec++;
      if (ppu_data_valid_out !== exp_v[c] || (exp_v[c] && ppu_data_out !== exp_d[c])) begin
        n_err++;
        $display("FAIL ppu burst cycle %0d: got v=%b d=%h want v=%b d=%h",
                 c, ppu_data_valid_out, ppu_data_out, exp_v[c], exp_d[c]);
      end
      next();
    end
    ppu_req_in = 1'b0;
  endtask

  task automatic test_lock();
    mode_in = 2'd2;
    cpu_read(16'hFE04, 8'hFF, "oam locked mode2 read");
    cpu_write(16'hFE04, 8'h55, "oam locked mode2 write");
    cpu_read(16'h8010, 8'h3C, "vram open in mode2");
    mode_in = 2'd3;
    cpu_read(16'h8010, 8'hFF, "vram locked mode3");
    cpu_write(16'h8010, 8'h99, "vram locked mode3 write");
    mode_in = 2'd0;
    cpu_read(16'hFE04, 8'h77, "oam readback mode0");
    cpu_read(16'h8010, 8'h3C, "vram readback mode0");
  endtask

  task automatic test_arbitration();
    mode_in = 2'd0;
    ppu_req_in = 1'b1; ppu_addr_in = 16'h8010;
    cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h8010;
    #1;
    n_vec++;
    if (cpu_ready_out !== 1'b0) begin
      n_err++; $display("FAIL arb same ram ready: got %b want 0", cpu_ready_out);
    end
    next();
    ppu_req_in = 1'b0;
    #1;
    n_vec++;
    if (cpu_ready_out !== 1'b1) begin
      n_err++; $display("FAIL arb retry ready: got %b want 1", cpu_ready_out);
    end
    next();
    cpu_req_in = 1'b0;
    #1;
    n_vec++;
    if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'h3C || cpu_rdata_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL arb ppu data: got pv=%b pd=%h cv=%b want pv=1 pd=3c cv=0",
               ppu_data_valid_out, ppu_data_out, cpu_rdata_valid_out);
    end
    next();
    n_vec++;
    if (cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== 8'h3C) begin
      n_err++; $display("FAIL arb cpu data: got v=%b d=%h want v=1 d=3c", cpu_rdata_valid_out, cpu_rdata_out);
    end
    next();
    ppu_req_in = 1'b1; ppu_addr_in = 16'hFE00;
    cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h8010;
    #1;
    n_vec++;
    if (cpu_ready_out !== 1'b1) begin
      n_err++; $display("FAIL arb diff ram ready: got %b want 1", cpu_ready_out);
    end
    next();
    ppu_req_in = 1'b0; cpu_req_in = 1'b0;
    next();
    n_vec++;
    if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'h20 ||
        cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== 8'h3C) begin
      n_err++;
      $display("FAIL arb diff ram data: got pv=%b pd=%h cv=%b cd=%h want 1 20 1 3c",
               ppu_data_valid_out, ppu_data_out, cpu_rdata_valid_out, cpu_rdata_out);
    end
    next();
  endtask

  task automatic test_write_first();
    mode_in = 2'd1;
    cpu_write(16'h8123, 8'hA5, "wf write");
    ppu_read(16'h8123, 8'hA5, "wf ppu read");
    ppu_read(16'hFEA0, 8'hFF, "ppu oam hole");
    ppu_read(16'h1234, 8'hFF, "ppu unmapped");
    mode_in = 2'd3;
    ppu_read(16'hFE00, 8'h20, "ppu ignores lock");
    mode_in = 2'd0;
    cpu_write(16'hC000, 8'h11, "cpu unmapped write");
    cpu_read(16'hC000, 8'hFF, "cpu unmapped read");
    cpu_read(16'hFE9F, 8'h00, "cpu oam last")
      ;
  endtask

  task automatic test_reset_mid();
    ppu_req_in = 1'b1; ppu_addr_in = 16'hFE00;
    next();
    ppu_req_in = 1'b0; rst_in = 1'b1;
    cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'hFE00;
    #1;
    n_vec++;
    if (cpu_ready_out !== 1'b0 || ppu_data_valid_out !== 1'b0 || cpu_rdata_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid reset outputs: got rdy=%b pv=%b cv=%b want 0 0 0",
               cpu_ready_out, ppu_data_valid_out, cpu_rdata_valid_out);
    end
    next();
    rst_in = 1'b0; cpu_req_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if (ppu_data_valid_out !== 1'b0 || ppu_data_out !== 8'h00 || cpu_rdata_valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL killed pulse cycle %0d: got pv=%b pd=%h cv=%b want 0 00 0",
                 c, ppu_data_valid_out, ppu_data_out, cpu_rdata_valid_out);
      end
      next();
    end
  endtask

`ifdef PPU_MEM_OAM_DMA_EN
  task automatic test_dma();
    int waited;
    mode_in = 2'd0;
    dma_page_in = 8'hC1; dma_start_in = 1'b1;
    next();
    dma_start_in = 1'b0;
    #1;
    n_vec++;
    if (dma_busy_out !== 1'b1 || dma_addr_out[15:8] !== 8'hC1) begin
      n_err++; $display("FAIL dma start: got busy=%b addr=%h want 1 c1xx", dma_busy_out, dma_addr_out);
    end
    cpu_read(16'hFE05, 8'hFF, "cpu oam during dma");
    waited = 0;
    while (dma_busy_out === 1'b1 && waited < 2000) begin
      next();
      waited++;
    end
    n_vec++;
    if (dma_busy_out !== 1'b0) begin
      n_err++; $display("FAIL dma timeout: busy=%b after %0d cycles want 0", dma_busy_out, waited);
    end
    cpu_read(16'hFE01, 8'hFE, "dma byte 1");
    cpu_read(16'hFE05, 8'hFA, "dma byte 5");
    cpu_read(16'hFE9F, 8'h60, "dma byte 159");
    ppu_read(16'hFE50, 8'hAF, "dma ppu byte 80");
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PPU_MEM_OAM_DMA_EN
    dma_start_in = 1'b0; dma_page_in = 8'h00;
`endif
    #1;
    test_reset();
    test_ppu_burst();
    test_lock();
    test_arbitration();
    test_write_first();
    test_reset_mid();
`ifdef PPU_MEM_OAM_DMA_EN
    test_dma();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_mem_responder.md
Name: ppu_mem_responder

Overview:
- Memory-side responder for PPU fetch requests: serves VRAM ($8000-$9FFF) and OAM ($FE00-$FE9F) reads with fixed latency and a valid strobe.
- Also arbitrates CPU accesses to the same memories, applying DMG mode-based locking (OAM locked in modes 2/3, VRAM locked in mode 3).
- Sits between the PPU, the CPU bus decoder and the on-chip RAMs.

Parameters:
- VRAM_BYTES, 8192, VRAM depth; address bits = $clog2(VRAM_BYTES).
- OAM_BYTES, 160, OAM depth (40 sprites x 4 bytes).
- RD_LATENCY, 2, cycles from accepted request to data_valid; legal values are 2 only (fixed pipeline, parameter exported for benches).

Ports:
- clk_in  in  1  system clock; sole clock.
- rst_in  in  1  synchronous, active-high reset.
- mode_in  in  2  PPU mode: 0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw.
- ppu_req_in  in  1  PPU read request strobe, one cycle per request.
- ppu_addr_in  in  16  PPU read address.
- ppu_data_out  out  8  read data to PPU.
- ppu_data_valid_out  out  1  one-cycle pulse, ppu_data_out valid.
- cpu_req_in  in  1  CPU access request.
- cpu_we_in  in  1  1 = write, 0 = read.
- cpu_addr_in  in  16  CPU address.
- cpu_wdata_in  in  8  CPU write data.
- cpu_ready_out  out  1  request accepted this cycle.
- cpu_rdata_out  out  8  CPU read data.
- cpu_rdata_valid_out  out  1  one-cycle pulse, cpu_rdata_out valid.

Behaviour:
- Reset: every output is 0, including cpu_ready_out, and the pipelines are flushed. RAM contents are not cleared. A reset mid-pipeline kills any in-flight valid; no valid pulse is issued for it after reset.
- Region decode: VRAM when addr[15:13]==3'b100. OAM when addr in $FE00-$FE9F. Anything else is unmapped.
- PPU path:
  - A request is always accepted.
  - Stage 1 registers the decode and address. Stage 2 performs the RAM read.
  - ppu_data_valid_out is asserted exactly 2 cycles after ppu_req_in.
  - Unmapped reads, and OAM addresses $FEA0-$FEFF, return $FF with valid.
  - PPU reads ignore locking.
  - Back-to-back requests on every cycle are supported at full throughput.
- CPU lock rules:
  - OAM is locked when mode_in is 2 or 3. VRAM is locked when mode_in is 3.
  - Locked reads return $FF; locked writes are dropped.
  - The lock is sampled in the acceptance cycle.
- Arbitration:
  - PPU and CPU requests to the same RAM in the same cycle: PPU wins, cpu_ready_out=0, and the CPU holds its request.
  - Requests to different RAMs both proceed.
  - Unmapped CPU accesses are accepted (ready=1). Reads return $FF; writes are dropped.
- CPU timing:
  - A read asserts cpu_rdata_valid_out 2 cycles after acceptance.
  - A write commits at the end of the acceptance cycle, with no valid pulse.
  - A PPU read of the same address in the next cycle sees the new data (write-first across the pipeline).
- Handshake FSM per port (IDLE, S1, S2), pipelined: a new accept in S1 or S2 creates overlapping entries, tracked as a 2-deep valid shift register.
- Address arithmetic: OAM index = addr[7:0], valid only if < OAM_BYTES. VRAM index = addr[12:0]. No wrap-around into the other region.

Optional Feature:
- Macro: PPU_MEM_OAM_DMA_EN.
- When defined:
  - Adds ports dma_start_in (1), dma_page_in (8), dma_addr_out (16), dma_data_in (8), dma_data_valid_in (1), dma_busy_out (1).
  - A DMA FSM (IDLE, REQ, WAIT, WRITE) copies 160 bytes from {dma_page_in,8'h00}+i into OAM[i], i=0..159.
  - While busy, the CPU sees OAM as locked regardless of mode. DMA writes take priority over CPU, but not over PPU reads in the same cycle.
  - dma_start_in while busy restarts at i=0. dma_busy_out drops the cycle after byte 159 is written.
- When undefined: none of these ports or logic exist.

Decomposition:
- Shared package ppu_pkg:
  - PPUState enum (HBlank=0, VBlank=1, OAMScan=2, Draw=3).
  - VRAM_BASE=$8000, OAM_BASE=$FE00, OAM_END=$FE9F.
  - OPEN_BUS=8'hFF.
  - Region enum {RegVRAM, RegOAM, RegNone}.
- Sub-module sync_ram_1r1w: parameterised depth/width, 1-cycle read, write-first. It is instantiated twice (VRAM, OAM).

Test Plan:
- PPU ppu_req_in on 3 consecutive cycles, addrs $FE00/$FE01/$8010 with OAM[0]=$20, OAM[1]=$08, VRAM[$10]=$3C -> valid on cycles +2,+3,+4 with data $20,$08,$3C.
- mode_in=2, CPU read $FE04 -> cpu_rdata_valid_out at +2 with $FF. CPU write $FE04=$55 then mode_in=0 and read back -> old value, not $55.
- mode_in=0, PPU and CPU request VRAM in the same cycle -> cpu_ready_out=0 that cycle and 1 the next; PPU data valid at +2.
- CPU write $8123=$A5 in mode 1, PPU read $8123 next cycle -> ppu_data_out=$A5 at +2. PPU read $FEA0 -> $FF with valid.
- Assert rst_in one cycle after ppu_req_in -> no ppu_data_valid_out pulse; all outputs 0 during and after reset.
- (PPU_MEM_OAM_DMA_EN) dma_page_in=$C1, source returns byte i=i^$FF -> OAM[i]=i^$FF for i=0..159, busy deasserts after the last write, CPU OAM read during busy returns $FF.
